// File: rtl/im_loader.sv
// Instruction-memory loader: receives a framed byte stream (16-bit word count,
// big-endian payload words, XOR checksum), writes the words into IM from word 0
// and keeps the CPU in reset until a load finishes with a matching checksum.
module im_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // IM capacity in words, held at 17 bits so a 16-bit length compares without overflow
  localparam logic [16:0] CAP_C = 17'd1 << ADDR_W;

  // Running checksum update: XOR of every payload byte
  function automatic logic [7:0] csum_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [15:0]        len_r;
  logic [23:0]        asm_r;
  logic [7:0]         csum_r;
  logic [1:0]         byte_idx_r;
  logic               xfer_s;
  logic               start_ok_s;
  logic               last_byte_s;
  logic               last_word_s;
  logic               active_nxt_s;
  logic [15:0]        len_s;
  logic [ADDR_W:0]    wc_inc_s;

  // Handshake, start qualification and word-completion decodes
  always_comb begin
    xfer_s       = byte_valid & byte_ready;
    start_ok_s   = start & ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERROR));
    last_byte_s  = (byte_idx_r == 2'd3);
    wc_inc_s     = word_count + {{ADDR_W{1'b0}}, 1'b1};
    last_word_s  = (17'(wc_inc_s) == {1'b0, len_r});
    len_s        = {len_r[15:8], byte_data};
  end

  // Next-state logic; the last word's write and the move to CHECK share one edge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nxt_s = S_LEN_HI;
        else       state_nxt_s = state_r;
      end
      S_LEN_HI: begin
        if (xfer_s) state_nxt_s = S_LEN_LO;
        else        state_nxt_s = S_LEN_HI;
      end
      S_LEN_LO: begin
        if (!xfer_s)                      state_nxt_s = S_LEN_LO;
        else if (len_s == 16'd0)          state_nxt_s = S_CHECK;
        else if ({1'b0, len_s} > CAP_C)   state_nxt_s = S_ERROR;
        else                              state_nxt_s = S_DATA;
      end
      S_DATA: begin
        if (xfer_s && last_byte_s && last_word_s) state_nxt_s = S_CHECK;
        else                                      state_nxt_s = S_DATA;
      end
      S_CHECK: begin
        if (!xfer_s)                 state_nxt_s = S_CHECK;
        else if (byte_data == csum_r) state_nxt_s = S_DONE;
        else                         state_nxt_s = S_ERROR;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_r
  always_comb begin
    active_nxt_s = (state_nxt_s == S_LEN_HI) | (state_nxt_s == S_LEN_LO) |
                   (state_nxt_s == S_DATA)   | (state_nxt_s == S_CHECK);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath: length capture, word assembly, checksum and IM write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= {ADDR_W{1'b0}};
      im_wdata   <= 32'h0000_0000;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= {(ADDR_W+1){1'b0}};
      len_r      <= 16'h0000;
      asm_r      <= 24'h00_0000;
      csum_r     <= 8'h00;
      byte_idx_r <= 2'd0;
    end else begin
      im_we      <= 1'b0;
      byte_ready <= active_nxt_s;
      busy       <= active_nxt_s;
      done       <= (state_nxt_s == S_DONE);
      error      <= (state_nxt_s == S_ERROR);
      cpu_reset  <= (state_nxt_s != S_DONE);
      if (start_ok_s) begin
        word_count <= {(ADDR_W+1){1'b0}};
        csum_r     <= 8'h00;
        byte_idx_r <= 2'd0;
        im_addr    <= {ADDR_W{1'b0}};
      end else if (xfer_s) begin
        case (state_r)
          S_LEN_HI: len_r[15:8] <= byte_data;
          S_LEN_LO: len_r[7:0]  <= byte_data;
          S_DATA: begin
            asm_r      <= {asm_r[15:0], byte_data};
            csum_r     <= csum_upd(csum_r, byte_data);
            byte_idx_r <= byte_idx_r + 2'd1;
            if (last_byte_s) begin
              im_we      <= 1'b1;
              im_wdata   <= {asm_r, byte_data};
              im_addr    <= word_count[ADDR_W-1:0];
              word_count <= wc_inc_s;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
